// File: rtl/aquila_init_pkg.sv
// rtl/aquila_init_pkg.sv - shared types, constants and LFSR step for aquila_mem_initiator
package aquila_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CODE_REQ,
        ST_CODE_WAIT,
        ST_DATA_REQ,
        ST_DATA_WAIT,
        ST_DONE,
        ST_ERROR
    } init_state_t;

    typedef enum logic [1:0] {
        ERR_NONE          = 2'd0,
        ERR_FETCH_TIMEOUT = 2'd1,
        ERR_READ_TIMEOUT  = 2'd2,
        ERR_DATA_MISMATCH = 2'd3
    } init_err_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] DATA_BASE = 32'h0000_1000;

    // Right-shifting Galois step: the bit shifted out folds the taps back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/aquila_init_scoreboard.sv
// rtl/aquila_init_scoreboard.sv - shadow copy of written data with valid bits and read compare
module aquila_init_scoreboard #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    input  logic [XLEN-1:0]          rd_data,
    output logic                     mismatch
);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] valid;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Entries never written in this run carry no expectation.
    assign mismatch = valid[rd_idx] && (mem[rd_idx] != rd_data);

endmodule

// File: rtl/aquila_mem_initiator.sv
// rtl/aquila_mem_initiator.sv - pseudo-random fetch/data initiator; AQUILA_INIT_CHECK_EN adds read-back checking
module aquila_mem_initiator
    import aquila_init_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_TXN      = 16,
    parameter int TIMEOUT      = 64,
    parameter int SHADOW_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [XLEN-1:0]   seed_i,
    input  logic              stall_i,
    output logic [XLEN-1:0]   code_addr_o,
    output logic              code_req_o,
    input  logic [XLEN-1:0]   code_i,
    input  logic              code_ready_i,
    output logic [XLEN-1:0]   data_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic              data_rw_o,
    output logic [XLEN/8-1:0] data_byte_enable_o,
    output logic              data_req_o,
    output logic              data_is_amo_o,
    output logic [4:0]        data_amo_type_o,
    output logic              cache_flush_o,
    input  logic [XLEN-1:0]   data_i,
    input  logic              data_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       txn_count_o,
    output logic [XLEN-1:0]   last_code_o
);

    localparam int IW = $clog2(SHADOW_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    init_state_t     state, state_nx;
    init_err_t       err_code;
    logic [31:0]     lfsr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] last_code;
    logic [15:0]     txn_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [IW-1:0]   idx;
    logic            is_write, timeout, txn_last, mismatch, idle_like;

    assign idx       = lfsr[IW+1:2];
    assign is_write  = lfsr[0];
    assign timeout   = (wait_cnt == TW'(TIMEOUT - 1));
    assign txn_last  = (txn_cnt == 16'(NUM_TXN - 1));
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Stall freezes the FSM and masks both requests and readies.
    always_comb begin
        state_nx   = state;
        code_req_o = 1'b0;
        data_req_o = 1'b0;
        if (!stall_i) begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) state_nx = ST_CODE_REQ;
                end
                ST_CODE_REQ: begin
                    code_req_o = 1'b1;
                    state_nx   = ST_CODE_WAIT;
                end
                ST_CODE_WAIT: begin
                    if (code_ready_i)  state_nx = ST_DATA_REQ;
                    else if (timeout)  state_nx = ST_ERROR;
                end
                ST_DATA_REQ: begin
                    data_req_o = 1'b1;
                    if (!is_write)     state_nx = ST_DATA_WAIT;
                    else if (txn_last) state_nx = ST_DONE;
                    else               state_nx = ST_CODE_REQ;
                end
                ST_DATA_WAIT: begin
                    if (data_ready_i) begin
                        if (mismatch)      state_nx = ST_ERROR;
                        else if (txn_last) state_nx = ST_DONE;
                        else               state_nx = ST_CODE_REQ;
                    end else if (timeout) begin
                        state_nx = ST_ERROR;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= 32'd1;
            pc        <= '0;
            last_code <= '0;
            txn_cnt   <= '0;
            wait_cnt  <= '0;
            err_code  <= ERR_NONE;
        end else if (!stall_i) begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        lfsr     <= (seed_i == '0) ? 32'd1 : 32'(seed_i);
                        pc       <= '0;
                        txn_cnt  <= '0;
                        err_code <= ERR_NONE;
                    end
                end
                ST_CODE_REQ: wait_cnt <= '0;
                ST_CODE_WAIT: begin
                    if (code_ready_i) begin
                        last_code <= code_i;
                        pc        <= pc + XLEN'(4);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout) err_code <= ERR_FETCH_TIMEOUT;
                    end
                end
                ST_DATA_REQ: begin
                    lfsr     <= lfsr_next(lfsr);
                    wait_cnt <= '0;
                    if (is_write) txn_cnt <= txn_cnt + 16'd1;
                end
                ST_DATA_WAIT: begin
                    if (data_ready_i) begin
                        if (mismatch) err_code <= ERR_DATA_MISMATCH;
                        else          txn_cnt  <= txn_cnt + 16'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout) err_code <= ERR_READ_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AQUILA_INIT_CHECK_EN
    logic [IW-1:0] rd_idx;

    // The LFSR has already stepped by DATA_WAIT, so the read index is held here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx <= '0;
        end else if (!stall_i && state == ST_DATA_REQ) begin
            rd_idx <= idx;
        end
    end

    aquila_init_scoreboard #(
        .DEPTH (SHADOW_DEPTH),
        .XLEN  (XLEN)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!stall_i && idle_like && start_i),
        .wr_en    (data_req_o && is_write),
        .wr_idx   (idx),
        .wr_data  (XLEN'(lfsr)),
        .rd_idx   (rd_idx),
        .rd_data  (data_i),
        .mismatch (mismatch)
    );
`else
    logic unused_data;
    assign unused_data = ^data_i;
    assign mismatch    = 1'b0;
`endif

    assign code_addr_o        = code_req_o ? pc : '0;
    assign data_addr_o        = data_req_o ? (XLEN'(DATA_BASE) + XLEN'({idx, 2'b00})) : '0;
    assign data_rw_o          = data_req_o && is_write;
    assign data_o             = (data_req_o && is_write) ? XLEN'(lfsr) : '0;
    assign data_byte_enable_o = '1;
    assign data_is_amo_o      = 1'b0;
    assign data_amo_type_o    = 5'd0;
    assign cache_flush_o      = 1'b0;

    assign busy_o      = !idle_like;
    assign done_o      = (state == ST_DONE);
    assign error_o     = (state == ST_ERROR);
    assign err_code_o  = err_code;
    assign txn_count_o = txn_cnt;
    assign last_code_o = last_code;

endmodule

// File: tb/tb_aquila_mem_initiator.sv
// tb/tb_aquila_mem_initiator.sv - randomized self-checking bench for aquila_mem_initiator
module tb_aquila_mem_initiator;

    localparam int XLEN         = 32;
    localparam int NUM_TXN      = 4;
    localparam int TIMEOUT      = 64;
    localparam int SHADOW_DEPTH = 8;
    localparam int STALL_CYC    = 70;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start_i = 1'b0;
    logic            stall_i = 1'b0;
    logic [XLEN-1:0] seed_i = '0;
    logic [XLEN-1:0] code_addr_o, data_o, data_addr_o, last_code_o;
    logic [XLEN-1:0] code_i = '0;
    logic [XLEN-1:0] data_i = '0;
    logic            code_req_o, data_req_o, data_rw_o, busy_o, done_o, error_o;
    logic            data_is_amo_o, cache_flush_o, code_ready_i, data_ready_i;
    logic [3:0]      data_byte_enable_o;
    logic [4:0]      data_amo_type_o;
    logic [1:0]      err_code_o;
    logic [15:0]     txn_count_o;

    aquila_mem_initiator #(
        .XLEN(XLEN), .NUM_TXN(NUM_TXN), .TIMEOUT(TIMEOUT), .SHADOW_DEPTH(SHADOW_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .seed_i(seed_i), .stall_i(stall_i),
        .code_addr_o(code_addr_o), .code_req_o(code_req_o), .code_i(code_i),
        .code_ready_i(code_ready_i), .data_o(data_o), .data_addr_o(data_addr_o),
        .data_rw_o(data_rw_o), .data_byte_enable_o(data_byte_enable_o),
        .data_req_o(data_req_o), .data_is_amo_o(data_is_amo_o),
        .data_amo_type_o(data_amo_type_o), .cache_flush_o(cache_flush_o),
        .data_i(data_i), .data_ready_i(data_ready_i), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .err_code_o(err_code_o), .txn_count_o(txn_count_o),
        .last_code_o(last_code_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Responder: sticky readies, memory that reflects writes, optional corruption of idx 2.
    logic            code_rdy_en = 1'b1;
    logic            corrupt = 1'b0;
    logic [31:0]     resp_mem [8];
    logic [31:0]     last_fetch = '0;
    logic [31:0]     obs_code_addr[$], obs_data_addr[$], obs_wdata[$];
    logic            obs_rw[$];
    int              busy_cycles = 0;

    assign code_ready_i = code_rdy_en;
    assign data_ready_i = 1'b1;

    always @(negedge clk) begin
        if (busy_o) busy_cycles++;
        if (code_req_o) begin
            obs_code_addr.push_back(code_addr_o);
            code_i     = $urandom;
            last_fetch = code_i;
        end
        if (data_req_o) begin
            obs_data_addr.push_back(data_addr_o);
            obs_rw.push_back(data_rw_o);
            obs_wdata.push_back(data_o);
            if (data_rw_o) resp_mem[data_addr_o[4:2]] = data_o;
            else data_i = resp_mem[data_addr_o[4:2]] ^
                          ((corrupt && data_addr_o[4:2] == 3'd2) ? 32'd1 : 32'd0);
        end
    end

    // Reference model: transaction list derived from the seed with plain arithmetic.
    logic [31:0] m_addr [NUM_TXN];
    logic [31:0] m_wdata[NUM_TXN];
    logic        m_rw   [NUM_TXN];
    int          m_n, m_cycles, m_err;
    bit          m_wr2rd2, m_has_read;

    task automatic build_model(input logic [31:0] seed);
        logic [31:0] l;
        int          idx;
        bit          written[8];
        l = (seed == 0) ? 32'd1 : seed;
        m_n = NUM_TXN; m_err = 0; m_cycles = 0; m_wr2rd2 = 0; m_has_read = 0;
        for (int k = 0; k < 8; k++) written[k] = 0;
        for (int i = 0; i < NUM_TXN; i++) begin
            idx        = int'((l / 4) % 8);
            m_rw[i]    = (l % 2) == 1;
            m_addr[i]  = 32'h1000 + 32'(idx * 4);
            m_wdata[i] = m_rw[i] ? l : 32'd0;
            m_cycles  += m_rw[i] ? 3 : 4;
            if (m_rw[i]) written[idx] = 1;
            else begin
                m_has_read = 1;
                if (idx == 2 && written[2]) m_wr2rd2 = 1;
`ifdef AQUILA_INIT_CHECK_EN
                if (corrupt && idx == 2 && written[2]) begin
                    m_n = i + 1; m_err = 3;
                    break;
                end
`endif
            end
            l = (l % 2 == 1) ? ((l / 2) ^ 32'h8020_0003) : (l / 2);
        end
    endtask

    task automatic find_seed(input bit want_wr2rd2, output logic [31:0] s);
        s = $urandom | 32'h1;
        for (int k = 0; k < 200000; k++) begin
            build_model(s);
            if (want_wr2rd2 ? m_wr2rd2 : m_has_read) return;
            s = s + 32'd2;
        end
    endtask

    task automatic start_run(input logic [31:0] seed);
        obs_code_addr.delete(); obs_data_addr.delete(); obs_wdata.delete(); obs_rw.delete();
        @(posedge clk); #1;
        busy_cycles = 0;
        seed_i  = seed;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic run(input logic [31:0] seed, input bit do_stall);
        logic [31:0] held_code;
        bit          exp_done;
        build_model(seed);
        start_run(seed);
        if (do_stall) begin
            @(posedge clk); #1;
            stall_i   = 1'b1;
            held_code = last_code_o;
            repeat (STALL_CYC) @(posedge clk);
            #1;
            check("stall_no_data_req", 64'(obs_data_addr.size()), 0);
            check("stall_no_error", error_o, 0);
            check("stall_busy", busy_o, 1);
            check("stall_last_code", last_code_o, held_code);
            stall_i = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("stall_resume_req", data_req_o, 1);
        end
        for (int c = 0; c < 400 && !(done_o || error_o); c++) @(negedge clk);
        #1;
        exp_done = (m_err == 0);
        check("run_finished", done_o | error_o, 1);
        check("done", done_o, exp_done);
        check("error", error_o, !exp_done);
        check("err_code", err_code_o, 64'(m_err));
        check("txn_count", txn_count_o, exp_done ? 64'(NUM_TXN) : 64'(m_n - 1));
        check("last_code", last_code_o, last_fetch);
        check("n_fetch", 64'(obs_code_addr.size()), 64'(m_n));
        check("n_data", 64'(obs_data_addr.size()), 64'(m_n));
        for (int i = 0; i < m_n && i < obs_data_addr.size() && i < obs_code_addr.size(); i++) begin
            check("code_addr", obs_code_addr[i], 32'(i * 4));
            check("data_addr", obs_data_addr[i], m_addr[i]);
            check("data_rw", obs_rw[i], m_rw[i]);
            check("data_wdata", obs_wdata[i], m_wdata[i]);
        end
        check("busy_cycles", 64'(busy_cycles), 64'(m_cycles + (do_stall ? STALL_CYC : 0)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {busy_o, done_o, error_o, err_code_o, code_req_o, data_req_o,
                                data_rw_o, data_is_amo_o, data_amo_type_o, cache_flush_o}, 0);
        check({tag, "_txn_count"}, txn_count_o, 0);
        check({tag, "_last_code"}, last_code_o, 0);
        check({tag, "_addrs"}, {code_addr_o, data_addr_o}, 0);
        check({tag, "_data_o"}, data_o, 0);
    endtask

    logic [31:0] q1_addr[$], q1_wdata[$];
    logic [31:0] s;
    bit          found;

    initial begin
        for (int i = 0; i < 8; i++) resp_mem[i] = $urandom;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_byte_en", data_byte_enable_o, 4'hF);
        rst_n = 1'b1;

        run(32'd1, 0);
        q1_addr  = obs_data_addr;
        q1_wdata = obs_wdata;
        run(32'd0, 0);
        check("seed0_len", 64'(obs_data_addr.size()), 64'(q1_addr.size()));
        for (int i = 0; i < q1_addr.size() && i < obs_data_addr.size(); i++) begin
            check("seed0_addr", obs_data_addr[i], q1_addr[i]);
            check("seed0_wdata", obs_wdata[i], q1_wdata[i]);
        end

        for (int r = 0; r < 6; r++) run($urandom, 0);

        code_rdy_en = 1'b0;
        start_run($urandom);
        for (int c = 0; c < 300 && !error_o; c++) @(negedge clk);
        #1;
        check("timeout_error", error_o, 1);
        check("timeout_done", done_o, 0);
        check("timeout_code", err_code_o, 1);
        check("timeout_txn", txn_count_o, 0);
        check("timeout_cycles", 64'(busy_cycles), 64'(TIMEOUT + 1));
        code_rdy_en = 1'b1;

        find_seed(1, s);
        corrupt = 1'b1;
        run(s, 0);
        corrupt = 1'b0;

        run($urandom, 1);

        find_seed(0, s);
        start_run(s);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (data_req_o && !data_rw_o) begin
                found = 1;
                break;
            end
        end
        check("rst_reach_read", found, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(s, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
